pipe_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage core. Takes register usage from the decode

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_ctrl_if.sv | 41 ++++
 rtl/pipe_ctrl_hazard_detect.sv | 23 ++
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Imported by the interface, the hazard comparator and the top.
package pipe_ctrl_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int STALL_CNT_W   = 32;

  localparam logic [REG_ADDR_W-1:0]    ZERO_REG_ADDR = '0;
  localparam logic [INST_ADDR_BUS-1:0] ZERO_WORD     = '0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic flush_if_id;
    logic flush_id_ex;
    logic stall_ex_mem;
    logic jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode/EX/data-bus status into the controller and hold/flush controls back out.
// master = pipeline side, slave = pipe_ctrl.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0]    id_rs1_i;
  logic [REG_ADDR_W-1:0]    id_rs2_i;
  logic                     id_rs1_used_i;
  logic                     id_rs2_used_i;
  logic [REG_ADDR_W-1:0]    ex_rd_i;
  logic                     ex_is_load_i;
  logic                     ex_jump_i;
  logic [INST_ADDR_BUS-1:0] ex_jump_addr_i;
  logic                     mem_req_i;
  logic                     mem_ack_i;

  logic                     stall_pc_o;
  logic                     stall_if_id_o;
  logic                     flush_if_id_o;
  logic                     flush_id_ex_o;
  logic                     stall_ex_mem_o;
  logic                     jump_o;
  logic [INST_ADDR_BUS-1:0] jump_addr_o;
  logic                     bus_err_o;
  logic [STALL_CNT_W-1:0]   stall_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i, ex_is_load_i,
           ex_jump_i, ex_jump_addr_i, mem_req_i, mem_ack_i,
    input  stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o, stall_ex_mem_o,
           jump_o, jump_addr_o, bus_err_o, stall_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i, ex_is_load_i,
           ex_jump_i, ex_jump_addr_i, mem_req_i, mem_ack_i,
    output stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o, stall_ex_mem_o,
           jump_o, jump_addr_o, bus_err_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use compare: a load in EX writing a register that a
// decoded source operand reads. Writes to x0 never create a hazard.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] src_addr_i,
  input  logic [NUM_SRC-1:0]                 src_used_i,
  input  logic [REG_ADDR_W-1:0]              ex_rd_i,
  input  logic                               ex_is_load_i,
  output logic                               hazard_o
);

  logic [NUM_SRC-1:0] src_hit;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_hit[i] = src_used_i[i] && (src_addr_i[i] == ex_rd_i);
  end

  assign hazard_o = ex_is_load_i && (ex_rd_i != ZERO_REG_ADDR) && (|src_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, jump redirect with a
// multi-cycle front-end flush, and data-memory wait with timeout.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int JUMP_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  localparam int                 WAIT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam int                 FLUSH_W      = $clog2(JUMP_FLUSH_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX     = WAIT_W'(MEM_TIMEOUT);
  localparam logic [FLUSH_W-1:0] FLUSH_RELOAD = FLUSH_W'(JUMP_FLUSH_CYCLES - 1);
  localparam bit                 HAS_FLUSH    = (JUMP_FLUSH_CYCLES > 1);

  state_e                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [FLUSH_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic                   jump_pend_q, jump_pend_d;
  logic                   bus_err_q, bus_err_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  ctrl_t ctrl, ctrl_out;
  logic  hazard, mem_stall, in_flush;

  hazard_detect #(.NUM_SRC(2)) u_hazard (
    .src_addr_i   ({bus.id_rs2_i, bus.id_rs1_i}),
    .src_used_i   ({bus.id_rs2_used_i, bus.id_rs1_used_i}),
    .ex_rd_i      (bus.ex_rd_i),
    .ex_is_load_i (bus.ex_is_load_i),
    .hazard_o     (hazard)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    jump_pend_d = jump_pend_q;
    bus_err_d   = 1'b0;
    ctrl        = CTRL_NONE;
    mem_stall   = bus.mem_req_i && !bus.mem_ack_i;
    in_flush    = (state_q == ST_FLUSH);

    unique case (state_q)
      ST_IDLE, ST_FLUSH: begin
        if (mem_stall) begin
          // A jump seen here is parked until the access completes; EX holds it stable.
          ctrl.stall_pc     = 1'b1;
          ctrl.stall_if_id  = 1'b1;
          ctrl.stall_ex_mem = 1'b1;
          ctrl.flush_id_ex  = 1'b1;
          ctrl.flush_if_id  = in_flush;
          state_d           = ST_MEM_WAIT;
          wait_cnt_d        = WAIT_W'(1);
          jump_pend_d       = bus.ex_jump_i;
        end else if (bus.ex_jump_i) begin
          ctrl.jump        = 1'b1;
          ctrl.flush_if_id = 1'b1;
          ctrl.flush_id_ex = 1'b1;
          flush_cnt_d      = FLUSH_RELOAD;
          state_d          = HAS_FLUSH ? ST_FLUSH : ST_IDLE;
        end else if (in_flush) begin
          ctrl.flush_if_id = 1'b1;
          ctrl.flush_id_ex = 1'b1;
          if (flush_cnt_q <= FLUSH_W'(1)) state_d = ST_IDLE;
          else                            flush_cnt_d = flush_cnt_q - 1'b1;
        end else if (hazard) begin
          ctrl.stall_pc    = 1'b1;
          ctrl.stall_if_id = 1'b1;
          ctrl.flush_id_ex = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (bus.mem_ack_i) begin
          // Ack cycle behaves like IDLE: the held EX instruction advances now.
          jump_pend_d = 1'b0;
          state_d     = ST_IDLE;
          if (jump_pend_q || bus.ex_jump_i) begin
            ctrl.jump        = 1'b1;
            ctrl.flush_if_id = 1'b1;
            ctrl.flush_id_ex = 1'b1;
            flush_cnt_d      = FLUSH_RELOAD;
            state_d          = HAS_FLUSH ? ST_FLUSH : ST_IDLE;
          end else if (hazard) begin
            ctrl.stall_pc    = 1'b1;
            ctrl.stall_if_id = 1'b1;
            ctrl.flush_id_ex = 1'b1;
          end
        end else if (wait_cnt_q == WAIT_MAX) begin
          bus_err_d   = 1'b1;
          jump_pend_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          ctrl.stall_pc     = 1'b1;
          ctrl.stall_if_id  = 1'b1;
          ctrl.stall_ex_mem = 1'b1;
          ctrl.flush_id_ex  = 1'b1;
          wait_cnt_d        = wait_cnt_q + 1'b1;
          jump_pend_d       = jump_pend_q || bus.ex_jump_i;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Discarding IF/ID takes precedence over holding it.
    if (ctrl.flush_if_id) ctrl.stall_if_id = 1'b0;
  end

  always_comb begin
    ctrl_out    = rst_n ? ctrl : CTRL_NONE;
    stall_cnt_d = ctrl_out.stall_pc ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      jump_pend_q <= 1'b0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      jump_pend_q <= jump_pend_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_pc_o     = ctrl_out.stall_pc;
  assign bus.stall_if_id_o  = ctrl_out.stall_if_id;
  assign bus.flush_if_id_o  = ctrl_out.flush_if_id;
  assign bus.flush_id_ex_o  = ctrl_out.flush_id_ex;
  assign bus.stall_ex_mem_o = ctrl_out.stall_ex_mem;
  assign bus.jump_o         = ctrl_out.jump;
  assign bus.jump_addr_o    = ctrl_out.jump ? bus.ex_jump_addr_i : ZERO_WORD;
  assign bus.bus_err_o      = bus_err_q;
  assign bus.stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, hand sequences for the
// multi-cycle cases, then random traffic against a behavioural model.
module tb_pipe_ctrl;

  localparam int JFC = 2;
  localparam int MT  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if bus();

  pipe_ctrl #(.JUMP_FLUSH_CYCLES(JFC), .MEM_TIMEOUT(MT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // ctrl bit order: {stall_pc, stall_if_id, flush_if_id, flush_id_ex, stall_ex_mem, jump}
  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        ld, jmp;
    logic [31:0] addr;
    logic        req, ack;
    logic [5:0]  ectl;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[9];

  // behavioural model: cycles waited on the bus, flush cycles still owed, parked jump
  int          m_wait, m_flush;
  bit          m_jpend, m_berr;
  logic [31:0] m_scnt;

  function automatic logic [5:0] dut_ctrl();
    return {bus.stall_pc_o, bus.stall_if_id_o, bus.flush_if_id_o,
            bus.flush_id_ex_o, bus.stall_ex_mem_o, bus.jump_o};
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic ld, input logic jmp,
                       input logic [31:0] addr, input logic req, input logic ack);
    bus.id_rs1_i = rs1;       bus.id_rs2_i = rs2;
    bus.id_rs1_used_i = u1;   bus.id_rs2_used_i = u2;
    bus.ex_rd_i = rd;         bus.ex_is_load_i = ld;
    bus.ex_jump_i = jmp;      bus.ex_jump_addr_i = addr;
    bus.mem_req_i = req;      bus.mem_ack_i = ack;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic chk_ctrl(input string nm, input logic [5:0] ectl, input logic [31:0] eaddr);
    n_chk++;
    if (dut_ctrl() !== ectl || bus.jump_addr_o !== eaddr) begin
      n_fail++;
      $display("FAIL %s: ctrl=%b addr=%h, expected ctrl=%b addr=%h",
               nm, dut_ctrl(), bus.jump_addr_o, ectl, eaddr);
    end
  endtask

  task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", nm, got, got, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    #1;
    chk_ctrl("rst_outputs", 6'b000000, 32'h0);
    chk_val("rst_bus_err", {31'd0, bus.bus_err_o}, 32'd0);
    chk_val("rst_stall_cnt", bus.stall_cnt_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic m_reset();
    m_wait = 0; m_flush = 0; m_jpend = 1'b0; m_berr = 1'b0; m_scnt = 32'd0;
  endtask

  // One clock of the rules: expected outputs for the current inputs, and the model advanced.
  task automatic model_step(output logic [5:0] ectl, output logic [31:0] eaddr);
    bit hz, sp, si, fi, fe, sm, jp, nberr;
    hz = bus.ex_is_load_i && (bus.ex_rd_i != 5'd0) &&
         ((bus.id_rs1_used_i && bus.id_rs1_i == bus.ex_rd_i) ||
          (bus.id_rs2_used_i && bus.id_rs2_i == bus.ex_rd_i));
    {sp, si, fi, fe, sm, jp, nberr} = '0;
    if (m_wait > 0) begin
      if (bus.mem_ack_i) begin
        if (m_jpend || bus.ex_jump_i) begin jp = 1; fi = 1; fe = 1; m_flush = JFC - 1; end
        else if (hz) begin sp = 1; si = 1; fe = 1; end
        m_wait = 0; m_jpend = 0;
      end else if (m_wait == MT) begin
        nberr = 1; m_wait = 0; m_jpend = 0;
      end else begin
        sp = 1; si = 1; sm = 1; fe = 1; m_wait++; m_jpend = m_jpend || bus.ex_jump_i;
      end
    end else if (bus.mem_req_i && !bus.mem_ack_i) begin
      sp = 1; si = 1; sm = 1; fe = 1; fi = (m_flush > 0);
      m_wait = 1; m_jpend = bus.ex_jump_i; m_flush = 0;
    end else if (bus.ex_jump_i) begin
      jp = 1; fi = 1; fe = 1; m_flush = JFC - 1;
    end else if (m_flush > 0) begin
      fi = 1; fe = 1; m_flush--;
    end else if (hz) begin
      sp = 1; si = 1; fe = 1;
    end
    if (fi) si = 0;
    eaddr = jp ? bus.ex_jump_addr_i : 32'h0;
    m_berr = nberr;
    if (sp && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
    ectl = {sp, si, fi, fe, sm, jp};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  ectl;
    logic [31:0] eaddr, e_scnt;
    logic        e_berr;
    int          ackp;

    vecs[0] = '{5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 32'h0,   0, 0, 6'b110100, 32'h0};   // lw x5; add x6,x5,x1
    vecs[1] = '{5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 32'h0,   0, 0, 6'b000000, 32'h0};   // load to x0
    vecs[2] = '{5'd3, 5'd7, 1, 1, 5'd7, 1, 0, 32'h0,   0, 0, 6'b110100, 32'h0};   // rs2 match
    vecs[3] = '{5'd3, 5'd7, 1, 0, 5'd7, 1, 0, 32'h0,   0, 0, 6'b000000, 32'h0};   // rs2 not read
    vecs[4] = '{5'd5, 5'd1, 1, 1, 5'd5, 0, 0, 32'h0,   0, 0, 6'b000000, 32'h0};   // not a load
    vecs[5] = '{5'd5, 5'd1, 1, 1, 5'd5, 1, 1, 32'h100, 0, 0, 6'b001101, 32'h100}; // jump beats load-use
    vecs[6] = '{5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 32'h0,   1, 1, 6'b110100, 32'h0};   // acked access, no mem stall
    vecs[7] = '{5'd5, 5'd1, 1, 1, 5'd5, 1, 1, 32'h300, 1, 0, 6'b110110, 32'h0};   // mem stall beats all
    vecs[8] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,   0, 0, 6'b000000, 32'h0};   // quiet

    idle();
    for (int i = 0; i < 9; i++) begin
      do_reset();
      @(negedge clk);
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd, vecs[i].ld,
            vecs[i].jmp, vecs[i].addr, vecs[i].req, vecs[i].ack);
      #1;
      chk_ctrl($sformatf("vec%0d", i), vecs[i].ectl, vecs[i].eaddr);
    end

    // Jump in IDLE, then one flush cycle during which load-use is ignored.
    do_reset();
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0); #1;
    chk_ctrl("jump_n", 6'b001101, 32'h100);
    @(negedge clk); drive(5, 1, 1, 1, 5, 1, 0, 32'h0, 0, 0); #1;
    chk_ctrl("jump_n1_flush", 6'b001100, 32'h0);
    @(negedge clk); idle(); #1;
    chk_ctrl("jump_n2_quiet", 6'b000000, 32'h0);

    // Jump during FLUSH restarts the flush.
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0); #1;
    chk_ctrl("rejump_first", 6'b001101, 32'h40);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0); #1;
    chk_ctrl("rejump_second", 6'b001101, 32'h80);
    @(negedge clk); idle(); #1;
    chk_ctrl("rejump_flush", 6'b001100, 32'h0);
    @(negedge clk); #1;
    chk_ctrl("rejump_done", 6'b000000, 32'h0);

    // Memory access acked after 3 stalled cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0); #1;
      chk_ctrl($sformatf("memwait_%0d", i), 6'b110110, 32'h0);
    end
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1); #1;
    chk_ctrl("memwait_ack", 6'b000000, 32'h0);
    @(negedge clk); idle(); #1;
    chk_val("memwait_stall_cnt", bus.stall_cnt_o, 32'd3);

    // No ack: 16 stalled cycles, timeout cycle releases, bus_err pulses next cycle.
    do_reset();
    for (int i = 0; i < MT; i++) begin
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0); #1;
      chk_ctrl($sformatf("tmo_wait_%0d", i), 6'b110110, 32'h0);
    end
    @(negedge clk); #1;
    chk_ctrl("tmo_release", 6'b000000, 32'h0);
    chk_val("tmo_no_err_yet", {31'd0, bus.bus_err_o}, 32'd0);
    @(negedge clk); idle(); #1;
    chk_val("tmo_bus_err", {31'd0, bus.bus_err_o}, 32'd1);
    chk_ctrl("tmo_idle", 6'b000000, 32'h0);
    chk_val("tmo_stall_cnt", bus.stall_cnt_o, 32'd16);
    @(negedge clk); #1;
    chk_val("tmo_err_pulse_end", {31'd0, bus.bus_err_o}, 32'd0);

    // Jump parked during MEM_WAIT, redirect on ack, reset mid-FLUSH.
    do_reset();
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 32'h200, 1, 0); #1;
    chk_ctrl("mwj_stall0", 6'b110110, 32'h0);
    @(negedge clk); #1;
    chk_ctrl("mwj_stall1", 6'b110110, 32'h0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 32'h200, 1, 1); #1;
    chk_ctrl("mwj_ack_jump", 6'b001101, 32'h200);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 32'h240, 0, 0); #1;
    chk_ctrl("mwj_flush_rejump", 6'b001101, 32'h240);
    rst_n = 1'b0; #1;
    chk_ctrl("mwj_in_reset", 6'b000000, 32'h0);
    chk_val("mwj_rst_cnt", bus.stall_cnt_o, 32'd0);
    @(negedge clk); rst_n = 1'b1; idle(); #1;
    chk_ctrl("mwj_after_reset", 6'b000000, 32'h0);
    @(negedge clk); #1;
    chk_ctrl("mwj_still_idle", 6'b000000, 32'h0);

    // Random traffic against the model, with occasional mid-run resets.
    do_reset();
    m_reset();
    for (int c = 0; c < 1500; c++) begin
      ackp = (c < 500) ? 50 : (c < 1000) ? 4 : 85;
      @(negedge clk);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 99) < 15),
            $urandom, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < ackp));
      #1;
      e_berr = m_berr;
      e_scnt = m_scnt;
      model_step(ectl, eaddr);
      n_chk++;
      if ({dut_ctrl(), bus.jump_addr_o, bus.bus_err_o, bus.stall_cnt_o} !==
          {ectl, eaddr, e_berr, e_scnt}) begin
        n_fail++;
        $display("FAIL rnd_cycle%0d: ctrl=%b addr=%h err=%b cnt=%0d, expected ctrl=%b addr=%h err=%b cnt=%0d",
                 c, dut_ctrl(), bus.jump_addr_o, bus.bus_err_o, bus.stall_cnt_o,
                 ectl, eaddr, e_berr, e_scnt);
      end
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        chk_ctrl($sformatf("rnd_reset%0d", c), 6'b000000, 32'h0);
        m_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
